// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared types, constants and helpers for the registered
//                3-to-8 decoder with hold (decoder_38_hold).
//                - tok_class_t : classification of an encoder bus token
//                - state_t     : decoder FSM state encoding
//                - tok_t       : FIFO entry {is_req, y}
//                - classify()  : maps encoder {GS, EO} to a token class
//                - onehot8()   : 3-bit index to 8-bit one-hot line
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // Token classes derived from the encoder's GS/EO pair
    typedef enum logic [1:0] {
        TOK_REQ  = 2'd0,   // gs=1, eo=0 : request on line y
        TOK_NONE = 2'd1,   // gs=0, eo=1 : enabled, no request
        TOK_DIS  = 2'd2,   // gs=0, eo=0 : encoder disabled
        TOK_ILL  = 2'd3    // gs=1, eo=1 : illegal combination
    } tok_class_t;

    // Decoder FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // FIFO entry: only REQ and NONE tokens are ever stored
    typedef struct packed {
        logic       is_req;
        logic [2:0] y;
    } tok_t;

    localparam int TOK_W = $bits(tok_t);

    function automatic tok_class_t classify(input logic gs, input logic eo);
        tok_class_t c;
        case ({gs, eo})
            2'b10:   c = TOK_REQ;
            2'b01:   c = TOK_NONE;
            2'b00:   c = TOK_DIS;
            default: c = TOK_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] y);
        return 8'b1 << y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_38_hold_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tok_fifo2
//  Description : Two-entry synchronous FIFO with full/empty flags and an
//                asynchronous active-high reset. Read data is the current
//                head (first-word fall-through style).
//  Ports       : clk, rst          - clock, async active-high reset
//                push, wr_data     - write strobe and data
//                pop               - remove the head entry
//                rd_data           - head entry
//                full, empty       - occupancy flags (decoded from a register)
//  Revision    : 1.0 - initial release
// ============================================================================
module tok_fifo2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_do_push;
    logic w_do_pop;

    // Guard against overflow/underflow even if a caller misbehaves
    assign w_do_push = push && (r_count != 2'd2);
    assign w_do_pop  = pop  && (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == 2'd2);
    assign empty   = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/decoder_38_hold.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_38_hold
//  Description : Registered 3-to-8 decoder on the receive side of an 8-3
//                priority encoder bus (Y, GS, EO). Tokens arrive over a
//                valid/ready handshake, are buffered in a 2-entry FIFO and
//                each one is presented for HOLD_CYCLES cycles.
//                REQ  -> one-hot line y, NONE -> idle hold with a pulse,
//                DIS  -> dropped, ILLEGAL -> dropped and sticky err.
//  Ports       : clk, rst                 - clock, async active-high reset
//                in_valid/in_ready        - input handshake
//                in_y, in_gs, in_eo       - encoder bus
//                out_onehot, out_valid    - held decode result
//                none_pulse               - start of a no-request hold
//                err                      - sticky illegal-token flag
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_38_hold #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_y,
    input  logic       in_gs,
    input  logic       in_eo,
    output logic [7:0] out_onehot,
    output logic       out_valid,
    output logic       none_pulse,
    output logic       err
);

    import decoder_pkg::*;

    localparam int                CNT_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(HOLD_CYCLES - 1);

    tok_class_t w_class;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    tok_t       w_push_tok;
    tok_t       w_head;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_onehot;
    logic             r_valid;
    logic             r_none_pulse;
    logic             r_err;

    assign w_class  = classify(in_gs, in_eo);
    assign w_accept = in_valid && in_ready;
    // DIS and ILLEGAL tokens are consumed at the handshake but never stored
    assign w_push   = w_accept && ((w_class == TOK_REQ) || (w_class == TOK_NONE));

    assign w_push_tok.is_req = (w_class == TOK_REQ);
    assign w_push_tok.y      = (w_class == TOK_REQ) ? in_y : 3'd0;

    // Pop either from idle or on the last hold cycle, so back-to-back tokens
    // follow each other without a bubble
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_HOLD) && (r_cnt == c_last_cnt)));

    tok_fifo2 #(
        .WIDTH (TOK_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .wr_data (w_push_tok),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_onehot     <= 8'h00;
            r_valid      <= 1'b0;
            r_none_pulse <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_none_pulse <= 1'b0;

            if (w_accept && (w_class == TOK_ILL)) begin
                r_err <= 1'b1;
            end

            if (w_pop) begin
                // Load the head token; shared by the IDLE entry and the
                // back-to-back reload at the end of a hold
                r_onehot     <= w_head.is_req ? onehot8(w_head.y) : 8'h00;
                r_valid      <= 1'b1;
                r_none_pulse <= !w_head.is_req;
                r_cnt        <= '0;
                r_state      <= ST_HOLD;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= '0;
                    end
                    ST_HOLD: begin
                        if (r_cnt == c_last_cnt) begin
                            r_onehot <= 8'h00;
                            r_valid  <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Full is decoded from the FIFO's count register only, so in_ready has
    // no combinational dependency on the input handshake
    assign in_ready   = !w_full;
    assign out_onehot = r_onehot;
    assign out_valid  = r_valid;
    assign none_pulse = r_none_pulse;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decoder_38_hold.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_38_hold
//  Description : Self-checking bench for decoder_38_hold. Two instances
//                (HOLD_CYCLES=4 and HOLD_CYCLES=1) share one input bus and
//                are compared every cycle against a token-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_38_hold;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_y;
    logic       in_gs;
    logic       in_eo;

    logic       a_ready, a_valid, a_pulse, a_err;
    logic [7:0] a_onehot;
    logic       b_ready, b_valid, b_pulse, b_err;
    logic [7:0] b_onehot;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per instance, a queue of pending tokens ({is_req,y}),
    // and the number of cycles the current token still has to be shown
    int         m_hold   [2];
    logic [7:0] m_onehot [2];
    logic       m_valid  [2];
    logic       m_pulse  [2];
    logic       m_err    [2];
    logic       m_ready  [2];
    logic [3:0] m_q0 [$];
    logic [3:0] m_q1 [$];

    always #5 clk = ~clk;

    decoder_38_hold #(.HOLD_CYCLES(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (a_ready),
        .in_y       (in_y),
        .in_gs      (in_gs),
        .in_eo      (in_eo),
        .out_onehot (a_onehot),
        .out_valid  (a_valid),
        .none_pulse (a_pulse),
        .err        (a_err)
    );

    decoder_38_hold #(.HOLD_CYCLES(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (b_ready),
        .in_y       (in_y),
        .in_gs      (in_gs),
        .in_eo      (in_eo),
        .out_onehot (b_onehot),
        .out_valid  (b_valid),
        .none_pulse (b_pulse),
        .err        (b_err)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold[i]   = 0;
            m_onehot[i] = 8'h00;
            m_valid[i]  = 1'b0;
            m_pulse[i]  = 1'b0;
            m_err[i]    = 1'b0;
            m_ready[i]  = 1'b1;
        end
        m_q0.delete();
        m_q1.delete();
    endtask

    // Advance one instance's model across one rising edge, using the inputs
    // present just before that edge
    task automatic model_step(input int i, input int hold);
        logic [3:0] q [$];
        logic [3:0] tok;
        logic       ready_pre;
        if (i == 0) q = m_q0; else q = m_q1;
        ready_pre  = (q.size() < 2);
        m_pulse[i] = 1'b0;
        if (m_hold[i] <= 1 && q.size() > 0) begin
            tok         = q.pop_front();
            m_hold[i]   = hold;
            m_valid[i]  = 1'b1;
            m_onehot[i] = tok[3] ? (8'd1 << tok[2:0]) : 8'h00;
            m_pulse[i]  = !tok[3];
        end else if (m_hold[i] == 1) begin
            m_hold[i]   = 0;
            m_valid[i]  = 1'b0;
            m_onehot[i] = 8'h00;
        end else if (m_hold[i] > 1) begin
            m_hold[i]   = m_hold[i] - 1;
        end
        if (in_valid && ready_pre) begin
            if (in_gs && !in_eo)      q.push_back({1'b1, in_y});
            else if (!in_gs && in_eo) q.push_back(4'b0000);
            else if (in_gs && in_eo)  m_err[i] = 1'b1;
        end
        m_ready[i] = (q.size() < 2);
        if (i == 0) m_q0 = q; else m_q1 = q;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_onehot", a_onehot,       m_onehot[0]);
        chk("a_valid",  {7'd0, a_valid}, {7'd0, m_valid[0]});
        chk("a_pulse",  {7'd0, a_pulse}, {7'd0, m_pulse[0]});
        chk("a_err",    {7'd0, a_err},   {7'd0, m_err[0]});
        chk("a_ready",  {7'd0, a_ready}, {7'd0, m_ready[0]});
        chk("b_onehot", b_onehot,       m_onehot[1]);
        chk("b_valid",  {7'd0, b_valid}, {7'd0, m_valid[1]});
        chk("b_pulse",  {7'd0, b_pulse}, {7'd0, m_pulse[1]});
        chk("b_err",    {7'd0, b_err},   {7'd0, m_err[1]});
        chk("b_ready",  {7'd0, b_ready}, {7'd0, m_ready[1]});
    endtask

    task automatic tick();
        model_step(0, 4);
        model_step(1, 1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic v, input logic [2:0] y, input logic gs, input logic eo);
        in_valid = v;
        in_y     = y;
        in_gs    = gs;
        in_eo    = eo;
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_y     = 3'd0;
        in_gs    = 1'b0;
        in_eo    = 1'b0;
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        check_all();

        // Single REQ y=5, held four cycles on the HOLD_CYCLES=4 instance
        send(1'b1, 3'd5, 1'b1, 1'b0);
        tick();
        chk("t1_first", a_onehot, 8'h20);
        idle(6);

        // Three back-to-back REQs fill the FIFO while the first one holds
        send(1'b1, 3'd0, 1'b1, 1'b0);
        send(1'b1, 3'd7, 1'b1, 1'b0);
        send(1'b1, 3'd3, 1'b1, 1'b0);
        chk("t2_full", {7'd0, a_ready}, 8'h00);
        idle(14);

        // NONE token: idle hold with a single pulse
        send(1'b1, 3'd6, 1'b0, 1'b1);
        idle(6);

        // DIS then ILLEGAL: nothing decoded, err becomes sticky
        send(1'b1, 3'd4, 1'b0, 1'b0);
        send(1'b1, 3'd2, 1'b1, 1'b1);
        chk("t4_err", {7'd0, a_err}, 8'h01);
        idle(4);

        // Streaming REQ 0..7; the HOLD_CYCLES=1 instance never stalls
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 3'(k), 1'b1, 1'b0);
            chk("t5_ready", {7'd0, b_ready}, 8'h01);
        end
        idle(12);

        // Async reset during the second hold cycle of REQ y=6 with y=1 queued
        send(1'b1, 3'd6, 1'b1, 1'b0);
        send(1'b1, 3'd1, 1'b1, 1'b0);
        idle(1);
        chk("t6_pre", a_onehot, 8'h40);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        idle(6);

        // Randomized traffic over all token classes
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            send(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 (r <= 5) || (r == 9), (r == 6) || (r == 7) || (r == 9));
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_38_hold.md
Name: decoder_38_hold

Overview:
- Registered 3-to-8 decoder that sits on the receive side of the 8-3 priority encoder's output bus (Y, GS, EO).
- Accepts encoded tokens over a valid/ready handshake and buffers up to two of them.
- Drives the matching one-hot line for a programmable number of cycles.
- Classifies the non-request codes: "no request" is held as idle time; "encoder disabled" and illegal codes are consumed and reported.

Parameters:
- HOLD_CYCLES, 4, cycles each decoded token is presented on out_onehot; legal range 1..255.
- CNT_W, $clog2(HOLD_CYCLES+1), width of the hold counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  token present on in_y/in_gs/in_eo.
- in_ready  output  1  block can accept a token this cycle.
- in_y  input  3  encoded index (encoder Y).
- in_gs  input  1  group-select (encoder GS): a request is present.
- in_eo  input  1  enable-out (encoder EO): enabled with no request.
- out_onehot  output  8  decoded line, bit in_y high while holding a request token.
- out_valid  output  1  high while any token (request or no-request) is being held.
- none_pulse  output  1  one-cycle pulse when a no-request token starts holding.
- err  output  1  sticky flag; set on an illegal token (in_gs=1 and in_eo=1); cleared only by rst.

Behaviour:
- Reset (async, active-high): out_onehot=8'h00, out_valid=0, none_pulse=0, err=0, FIFO empty, FSM=IDLE, counter=0. in_ready=1 in the first cycle after rst deasserts.
- Handshake: a token transfers on a rising edge with in_valid & in_ready. in_ready = !fifo_full and is registered (no combinational path from the output side).
- Token classification at push:
  - gs=1, eo=0: REQ(y).
  - gs=0, eo=1: NONE.
  - gs=0, eo=0: DIS. Dropped at push and never enters the FIFO.
  - gs=1, eo=1: ILLEGAL. Dropped at push; err set on the same edge.
  - in_y is ignored for every class except REQ.
- FIFO: 2 entries; each entry holds {is_req, y[2:0]}. A push into a full FIFO cannot occur because in_ready=0.
- FSM states: IDLE and HOLD.
  - IDLE & FIFO non-empty: pop the head. Load out_onehot = is_req ? (8'b1 << y) : 8'h00 and set out_valid=1. none_pulse=1 for that cycle if the head is NONE. Counter=0; go to HOLD.
  - HOLD: counter increments each cycle.
  - At counter == HOLD_CYCLES-1, FIFO non-empty: pop the next token back-to-back with no bubble and restart the counter at 0.
  - At counter == HOLD_CYCLES-1, FIFO empty: clear out_onehot and out_valid; go to IDLE.
- Latency: a token accepted at edge k into an empty FIFO with the FSM in IDLE appears on the outputs after edge k+1. It is held for exactly HOLD_CYCLES cycles.
- Simultaneous push and pop in one cycle: both take effect; occupancy is unchanged.
- HOLD_CYCLES=1: every held token occupies one cycle; sustained throughput is 1 token/cycle.
- out_onehot is always zero or exactly one-hot; it is never multi-hot.
- Reset mid-HOLD: all state clears immediately (async). Queued tokens are discarded; none are replayed.

Decomposition:
- Shared package decoder_pkg:
  - Token class encoding: TOK_REQ, TOK_NONE, TOK_DIS, TOK_ILL.
  - FSM state constants: ST_IDLE, ST_HOLD.
  - Function onehot8(y) returning 8'b1 << y.
- One natural sub-module: tok_fifo2, a 2-entry synchronous FIFO with full/empty flags, same clk/rst. The FSM and decode stay in the top.

Test Plan:
1. Reset release, then push REQ y=5 at edge 1, HOLD_CYCLES=4 -> out_onehot=8'h20 and out_valid=1 after edges 2..5; 8'h00 and out_valid=0 after edge 6.
2. Push REQ y=0, REQ y=7, REQ y=3 on consecutive cycles -> in_ready drops to 0 after the third push (FIFO full while the first token holds); outputs 8'h01, 8'h80, 8'h08, each held 4 cycles with no gap cycle.
3. Push NONE (gs=0, eo=1) -> out_valid=1 and out_onehot=8'h00 for 4 cycles; none_pulse high for exactly the first of those cycles.
4. Push DIS (gs=0, eo=0), then ILLEGAL (gs=1, eo=1, y=2) -> outputs never assert; err=1 from the edge after the ILLEGAL push and stays 1 until rst.
5. HOLD_CYCLES=1: stream REQ y=0..7 with in_valid held high -> out_onehot walks 01,02,04,...,80 one per cycle and in_ready never drops.
6. Assert rst asynchronously in the middle of cycle 2 of a REQ y=6 hold with one token queued -> out_onehot=0, out_valid=0, err=0 immediately; after release no queued token appears.
